// File: rtl/sha256_folded_core.sv
// Iterative SHA-256 compression core: UNROLL rounds per clock over a sliding 16-word
// message schedule window, with a valid/ready handshake on both sides.
module sha256_folded_core #(
  parameter int unsigned UNROLL      = 1,
  parameter int unsigned FEEDFORWARD = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rx_valid,
  output logic         rx_ready,
  input  logic [511:0] rx_data,
  input  logic [255:0] rx_state,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic [255:0] tx_hash,
  output logic [31:0]  tx_midhash,
  output logic         busy
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4 || UNROLL == 8)) begin : gen_bad_unroll
    $error("sha256_folded_core: UNROLL must be 1, 2, 4 or 8");
  end

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  state_e        state_q, state_d;
  logic [5:0]    round_q, round_d;
  logic [31:0]   w_q [16];
  logic [31:0]   w_d [16];
  logic [31:0]   s_q [8];
  logic [31:0]   s_d [8];
  logic [31:0]   init_q [8];
  logic [31:0]   init_d [8];
  logic [255:0]  hash_q, hash_d;
  logic [31:0]   mid_q, mid_d;

  // Result of applying UNROLL rounds to the current working state and window.
  logic [31:0]   rnd_w [16];
  logic [31:0]   rnd_s [8];
  logic [31:0]   rnd_mid;
  logic          last_chunk;
  logic          accept;

  always_comb begin : p_rounds
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] wnew;
    rnd_w   = w_q;
    rnd_s   = s_q;
    rnd_mid = mid_q;
    t1      = '0;
    t2      = '0;
    wnew    = '0;
    for (int i = 0; i < int'(UNROLL); i++) begin
      t1 = rnd_s[7] + big_sigma1(rnd_s[4]) +
           ((rnd_s[4] & rnd_s[5]) ^ (~rnd_s[4] & rnd_s[6])) +
           K[round_q + 6'(i)] + rnd_w[0];
      t2 = big_sigma0(rnd_s[0]) +
           ((rnd_s[0] & rnd_s[1]) ^ (rnd_s[0] & rnd_s[2]) ^ (rnd_s[1] & rnd_s[2]));
      for (int j = 7; j > 0; j--) begin
        rnd_s[j] = rnd_s[j-1];
      end
      rnd_s[4] = rnd_s[4] + t1;
      rnd_s[0] = t1 + t2;
      if ((round_q + 6'(i)) == 6'd60) begin
        rnd_mid = rnd_s[4];
      end
      wnew = small_sigma1(rnd_w[14]) + rnd_w[9] + small_sigma0(rnd_w[1]) + rnd_w[0];
      for (int j = 0; j < 15; j++) begin
        rnd_w[j] = rnd_w[j+1];
      end
      rnd_w[15] = wnew;
    end
  end

  assign last_chunk = (round_q == 6'(64 - UNROLL));

  always_comb begin : p_next
    state_d  = state_q;
    round_d  = round_q;
    w_d      = w_q;
    s_d      = s_q;
    init_d   = init_q;
    hash_d   = hash_q;
    mid_d    = mid_q;
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      StIdle: begin
        rx_ready = 1'b1;
      end
      StRound: begin
        busy    = 1'b1;
        w_d     = rnd_w;
        s_d     = rnd_s;
        mid_d   = rnd_mid;
        round_d = round_q + 6'(UNROLL);
        if (last_chunk) begin
          for (int k = 0; k < 8; k++) begin
            hash_d[32*k +: 32] = rnd_s[k] + ((FEEDFORWARD != 0) ? init_q[k] : 32'd0);
          end
          state_d = StDone;
        end
      end
      StDone: begin
        tx_valid = 1'b1;
        rx_ready = tx_ready;
        if (tx_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (reset) begin
      rx_ready = 1'b0;
    end
    accept = rx_valid && rx_ready;
    if (accept) begin
      for (int i = 0; i < 16; i++) begin
        w_d[i] = rx_data[32*i +: 32];
      end
      for (int k = 0; k < 8; k++) begin
        s_d[k]    = rx_state[32*k +: 32];
        init_d[k] = rx_state[32*k +: 32];
      end
      round_d = '0;
      state_d = StRound;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      round_q <= '0;
      hash_q  <= '0;
      mid_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      hash_q  <= hash_d;
      mid_q   <= mid_d;
    end
  end

  // Datapath contents are only meaningful after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    w_q    <= w_d;
    s_q    <= s_d;
    init_q <= init_d;
  end

  assign tx_hash    = hash_q;
  assign tx_midhash = mid_q;

endmodule

// File: tb/tb_sha256_folded_core.sv
// Directed and randomised checks of sha256_folded_core for UNROLL 1/2/4/8 and no feed-forward.
module tb_sha256_folded_core;

  localparam int NDUT = 5;
  localparam int unsigned UN  [NDUT] = '{1, 2, 4, 8, 1};
  localparam int unsigned FFP [NDUT] = '{1, 1, 1, 1, 0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVW [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] ABC_HW [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  logic         clk = 1'b0;
  logic         reset;
  logic         rx_valid   [NDUT];
  logic         rx_ready   [NDUT];
  logic [511:0] rx_data    [NDUT];
  logic [255:0] rx_state   [NDUT];
  logic         tx_valid   [NDUT];
  logic         tx_ready   [NDUT];
  logic [255:0] tx_hash    [NDUT];
  logic [31:0]  tx_midhash [NDUT];
  logic         busy       [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : gen_dut
    sha256_folded_core #(
      .UNROLL      (UN[g]),
      .FEEDFORWARD (FFP[g])
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid[g]),
      .rx_ready   (rx_ready[g]),
      .rx_data    (rx_data[g]),
      .rx_state   (rx_state[g]),
      .tx_valid   (tx_valid[g]),
      .tx_ready   (tx_ready[g]),
      .tx_hash    (tx_hash[g]),
      .tx_midhash (tx_midhash[g]),
      .busy       (busy[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [511:0] abc_blk;
  logic [255:0] iv;
  logic [255:0] abc_hash;
  logic [255:0] raw_q [$];
  logic [255:0] st_q  [$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-word schedule, no feed-forward.
  function automatic logic [255:0] sha_raw(input logic [511:0] blk, input logic [255:0] st);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2, s0, s1;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[32*t +: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = s1 + w[t-7] + s0 + w[t-16];
    end
    for (int k = 0; k < 8; k++) v[k] = st[32*k +: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int k = 0; k < 8; k++) r[32*k +: 32] = v[k];
    return r;
  endfunction

  function automatic logic [255:0] ff_add(input logic [255:0] raw, input logic [255:0] st,
                                          input int unsigned ff);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) begin
      r[32*k +: 32] = raw[32*k +: 32] + ((ff != 0) ? st[32*k +: 32] : 32'd0);
    end
    return r;
  endfunction

  task automatic wait_valid(input int n, output int cyc);
    cyc = 0;
    while (!tx_valid[n] && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic check_abc_result(input int n);
    if (FFP[n] != 0) begin
      check($sformatf("abc hash u%0d", n), tx_hash[n], abc_hash);
    end else begin
      check($sformatf("abc nff word0 u%0d", n), 256'(tx_hash[n][31:0]), 256'(32'h506e3058));
      check($sformatf("abc nff word7 u%0d", n), 256'(tx_hash[n][255:224]), 256'(32'h961f4894));
    end
    check($sformatf("abc midhash u%0d", n), 256'(tx_midhash[n]), 256'(32'h961f4894));
  endtask

  // Presents "abc" to an idle DUT and leaves it in DONE with tx_ready low.
  task automatic run_abc(input int n);
    int cyc;
    rx_data[n]  = abc_blk;
    rx_state[n] = iv;
    rx_valid[n] = 1'b1;
    tx_ready[n] = 1'b0;
    check($sformatf("idle rx_ready u%0d", n), 256'(rx_ready[n]), 256'(1'b1));
    tick();
    rx_valid[n] = 1'b0;
    rx_data[n]  = '1;
    rx_state[n] = '1;
    check($sformatf("busy after accept u%0d", n), 256'(busy[n]), 256'(1'b1));
    wait_valid(n, cyc);
    check($sformatf("latency u%0d", n), 256'(cyc), 256'(64 / UN[n]));
    check_abc_result(n);
  endtask

  task automatic release_result(input int n);
    tx_ready[n] = 1'b1;
    tick();
    tx_ready[n] = 1'b0;
    #1;
    check($sformatf("tx_valid drop u%0d", n), 256'(tx_valid[n]), 256'(1'b0));
    check($sformatf("back to idle u%0d", n), 256'(rx_ready[n]), 256'(1'b1));
  endtask

  task automatic rand_run(input int n, input int nblk);
    logic [511:0] b;
    logic [255:0] s, raw, st;
    logic         acc;
    int           wt, got, cyc;
    raw_q.delete();
    st_q.delete();
    fork
      begin
        for (int i = 0; i < nblk; i++) begin
          for (int j = 0; j < 16; j++) b[32*j +: 32] = $urandom();
          for (int j = 0; j < 8; j++)  s[32*j +: 32] = $urandom();
          while ($urandom_range(0, 3) == 0) tick();
          rx_valid[n] = 1'b1;
          rx_data[n]  = b;
          rx_state[n] = s;
          acc = 1'b0;
          wt  = 0;
          while (!acc && wt < 300) begin
            @(negedge clk);
            acc = rx_ready[n];
            tick();
            wt++;
          end
          rx_valid[n] = 1'b0;
          rx_data[n]  = {16{$urandom()}};
          rx_state[n] = {8{$urandom()}};
          if (!acc) begin
            check($sformatf("rand accept timeout u%0d", n), 256'(acc), 256'(1'b1));
            break;
          end
          raw_q.push_back(sha_raw(b, s));
          st_q.push_back(s);
        end
      end
      begin
        got = 0;
        cyc = 0;
        while (got < nblk && cyc < 40000) begin
          tx_ready[n] = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (tx_valid[n] && tx_ready[n]) begin
            if (raw_q.size() == 0) begin
              check($sformatf("rand extra output u%0d", n), 256'(raw_q.size()), 256'(1));
            end else begin
              raw = raw_q.pop_front();
              st  = st_q.pop_front();
              check($sformatf("rand hash u%0d #%0d", n, got), tx_hash[n], ff_add(raw, st, FFP[n]));
              check($sformatf("rand midhash u%0d #%0d", n, got), 256'(tx_midhash[n]),
                    256'(raw[255:224]));
            end
            got++;
          end
          tick();
          cyc++;
        end
        tx_ready[n] = 1'b0;
        check($sformatf("rand result count u%0d", n), 256'(got), 256'(nblk));
      end
    join
    repeat (80) tick();
    check($sformatf("rand no leftover u%0d", n), 256'(tx_valid[n]), 256'(1'b0));
    check($sformatf("rand queue empty u%0d", n), 256'(raw_q.size()), 256'(0));
  endtask

  initial begin
    logic [255:0] held;
    int           cyc;
    for (int k = 0; k < 8; k++) begin
      iv[32*k +: 32]       = IVW[k];
      abc_hash[32*k +: 32] = ABC_HW[k];
    end
    abc_blk         = '0;
    abc_blk[31:0]   = 32'h61626380;
    abc_blk[511:480] = 32'h00000018;
    for (int n = 0; n < NDUT; n++) begin
      rx_valid[n] = 1'b0;
      tx_ready[n] = 1'b0;
      rx_data[n]  = '0;
      rx_state[n] = '0;
    end

    // Reset state; rx_valid high during reset must not be accepted.
    reset = 1'b1;
    rx_valid[0] = 1'b1;
    tick();
    tick();
    for (int n = 0; n < NDUT; n++) begin
      check($sformatf("reset rx_ready u%0d", n), 256'(rx_ready[n]), 256'(1'b0));
      check($sformatf("reset tx_valid u%0d", n), 256'(tx_valid[n]), 256'(1'b0));
      check($sformatf("reset tx_hash u%0d", n), tx_hash[n], 256'(0));
      check($sformatf("reset midhash u%0d", n), 256'(tx_midhash[n]), 256'(0));
    end
    rx_valid[0] = 1'b0;
    reset = 1'b0;
    #1;
    check("post-reset busy u0", 256'(busy[0]), 256'(1'b0));

    // Known vector on every variant.
    for (int n = 0; n < NDUT; n++) begin
      run_abc(n);
      release_result(n);
    end

    // Backpressure in DONE, then accept a new block on the release edge.
    run_abc(0);
    held = tx_hash[0];
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold tx_valid %0d", i), 256'(tx_valid[0]), 256'(1'b1));
      check($sformatf("hold tx_hash %0d", i), tx_hash[0], held);
      check($sformatf("hold rx_ready %0d", i), 256'(rx_ready[0]), 256'(1'b0));
    end
    tx_ready[0] = 1'b1;
    rx_valid[0] = 1'b1;
    rx_data[0]  = abc_blk;
    rx_state[0] = iv;
    #1;
    check("done rx_ready follows tx_ready", 256'(rx_ready[0]), 256'(1'b1));
    tick();
    tx_ready[0] = 1'b0;
    rx_valid[0] = 1'b0;
    check("back-to-back busy", 256'(busy[0]), 256'(1'b1));
    check("back-to-back tx_valid drop", 256'(tx_valid[0]), 256'(1'b0));
    wait_valid(0, cyc);
    check("back-to-back latency", 256'(cyc), 256'(64));
    check_abc_result(0);
    release_result(0);

    // Abort at round 30 with a one-cycle reset.
    rx_valid[0] = 1'b1;
    rx_data[0]  = abc_blk;
    rx_state[0] = iv;
    tick();
    rx_valid[0] = 1'b0;
    repeat (30) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort tx_valid", 256'(tx_valid[0]), 256'(1'b0));
    check("abort tx_hash", tx_hash[0], 256'(0));
    check("abort midhash", 256'(tx_midhash[0]), 256'(0));
    check("abort rx_ready", 256'(rx_ready[0]), 256'(1'b1));
    check("abort busy", 256'(busy[0]), 256'(1'b0));
    repeat (70) tick();
    check("abort no late output", 256'(tx_valid[0]), 256'(1'b0));
    run_abc(0);
    release_result(0);

    // Randomised traffic against the software model.
    for (int n = 0; n < 4; n++) begin
      rand_run(n, 200);
    end
    rand_run(4, 40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
